qcw_burst_sequencer: RTL and testbench

- Sits directly upstream of the QCW PLL/oscillator stage and drives its start, halt, phase_shift and cycle_limit inputs.
- Consumes the PLL's cycle_finished, done and fault outputs.
- Turns a fire request into one QCW burst with a linear phase-shift power ramp, enforces a cooldown between bursts, and latches, retries and locks out on faults.
- One clock domain, shared with the PLL.

---
 rtl/qcw_burst_sequencer_if.sv | 31 +++
 rtl/qcw_burst_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_qcw_burst_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qcw_burst_sequencer_if.sv
// Sequencer <-> QCW PLL/oscillator control bundle.
// master: sequencer side, slave: PLL side.
interface qcw_burst_sequencer_if;
    logic        start;
    logic        halt;
    logic [7:0]  phase_shift;
    logic [15:0] cycle_limit;
    logic        cycle_finished;
    logic        done;
    logic        fault;

    modport master (
        output start,
        output halt,
        output phase_shift,
        output cycle_limit,
        input  cycle_finished,
        input  done,
        input  fault
    );

    modport slave (
        input  start,
        input  halt,
        input  phase_shift,
        input  cycle_limit,
        output cycle_finished,
        output done,
        output fault
    );
endinterface

// File: rtl/qcw_burst_sequencer.sv
// QCW burst sequencer: fire -> ramped burst, cooldown, fault retry/lockout.
// Optional QCW_SEQ_BURST_CNT_EN adds burst_cnt and peak_phase outputs.
module qcw_burst_sequencer #(
    parameter int unsigned RAMP_START       = 16,
    parameter int unsigned RAMP_END         = 200,
    parameter int unsigned RAMP_STEP_CYCLES = 4,
    parameter int unsigned CYCLE_LIMIT      = 2000,
    parameter int unsigned COOLDOWN_CLKS    = 1000000,
    parameter int unsigned WDOG_CLKS        = 4096,
    parameter int unsigned RETRY_LIMIT      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fire,
    qcw_burst_sequencer_if.master pll,
    output logic                  busy,
    output logic                  fault_latched,
    output logic                  lockout
`ifdef QCW_SEQ_BURST_CNT_EN
    ,
    output logic [15:0]           burst_cnt,
    output logic [7:0]            peak_phase
`endif
);

    localparam logic [7:0]  PH_START  = 8'(RAMP_START);
    localparam logic [7:0]  PH_END    = 8'(RAMP_END);
    localparam logic [15:0] STEP_LAST = 16'(RAMP_STEP_CYCLES - 1);
    localparam logic [23:0] COOL_LAST = 24'(COOLDOWN_CLKS - 1);
    localparam logic [15:0] WDOG_MAX  = 16'(WDOG_CLKS);
    localparam logic [3:0]  RETRY_MAX = 4'(RETRY_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RAMP,
        S_COOL,
        S_FAULT,
        S_LOCK
    } state_t;

    state_t      state_q, state_d;
    logic        fire_q, cf_q;
    logic        start_q, start_d;
    logic        halt_q, halt_d;
    logic [7:0]  phase_q, phase_d;
    logic        busy_q, busy_d;
    logic        flt_q, flt_d;
    logic        lock_q, lock_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] step_q, step_d;
    logic [15:0] wdog_q, wdog_d;
    logic        hold_q, hold_d;
    logic [23:0] cool_q, cool_d;

    logic        fire_rise;
    logic        cf_rise;
    logic [3:0]  retry_inc;
    logic [7:0]  phase_inc;
    logic [15:0] wdog_inc;

`ifdef QCW_SEQ_BURST_CNT_EN
    logic [15:0] bcnt_q, bcnt_d;
    logic [7:0]  peak_q, peak_d;
`endif

    assign fire_rise = fire & ~fire_q;
    assign cf_rise   = pll.cycle_finished & ~cf_q;
    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    assign phase_inc = (phase_q >= PH_END) ? PH_END : phase_q + 8'd1;
    assign wdog_inc  = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        halt_d  = halt_q;
        phase_d = PH_START;
        flt_d   = flt_q;
        retry_d = retry_q;
        step_d  = step_q;
        wdog_d  = wdog_q;
        hold_d  = hold_q;
        cool_d  = cool_q;
`ifdef QCW_SEQ_BURST_CNT_EN
        bcnt_d  = bcnt_q;
        peak_d  = peak_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                halt_d = 1'b0;
                if (enable && fire_rise) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    hold_d  = 1'b0;
                end
            end
            // Stale done/fault from the previous burst is ignored here.
            S_START: begin
                hold_d = 1'b1;
                if (hold_q) begin
                    state_d = S_RAMP;
                    step_d  = 16'd0;
                    wdog_d  = 16'd0;
                end
            end
            S_RAMP: begin
                phase_d = phase_q;
                if (!enable) begin
                    halt_d = 1'b1;
                end
                wdog_d = cf_rise ? 16'd0 : wdog_inc;
                if (cf_rise) begin
                    if (step_q >= STEP_LAST) begin
                        step_d  = 16'd0;
                        phase_d = phase_inc;
                    end else begin
                        step_d = step_q + 16'd1;
                    end
                end
                if (pll.fault || (wdog_q >= WDOG_MAX)) begin
                    // An operator abort ends quietly, not as a fault.
                    halt_d  = 1'b0;
                    phase_d = PH_START;
                    cool_d  = 24'd0;
                    if (halt_q) begin
                        state_d = S_COOL;
                    end else begin
                        state_d = S_FAULT;
                        flt_d   = 1'b1;
                    end
                end else if (pll.done) begin
                    state_d = S_COOL;
                    halt_d  = 1'b0;
                    phase_d = PH_START;
                    cool_d  = 24'd0;
                    flt_d   = 1'b0;
`ifdef QCW_SEQ_BURST_CNT_EN
                    bcnt_d  = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
                    peak_d  = phase_q;
`endif
                end
            end
            S_COOL: begin
                halt_d = 1'b0;
                cool_d = cool_q + 24'd1;
                if (cool_q >= COOL_LAST) begin
                    state_d = S_IDLE;
                    cool_d  = 24'd0;
                end
            end
            S_FAULT: begin
                flt_d   = 1'b1;
                retry_d = retry_inc;
                if (retry_inc >= RETRY_MAX) begin
                    state_d = S_LOCK;
                end else begin
                    state_d = S_COOL;
                    cool_d  = 24'd0;
                end
            end
            S_LOCK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    retry_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        lock_d = (state_d == S_LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fire_q  <= 1'b0;
            cf_q    <= 1'b0;
            start_q <= 1'b0;
            halt_q  <= 1'b0;
            phase_q <= PH_START;
            busy_q  <= 1'b0;
            flt_q   <= 1'b0;
            lock_q  <= 1'b0;
            retry_q <= 4'd0;
            step_q  <= 16'd0;
            wdog_q  <= 16'd0;
            hold_q  <= 1'b0;
            cool_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            fire_q  <= fire;
            cf_q    <= pll.cycle_finished;
            start_q <= start_d;
            halt_q  <= halt_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            flt_q   <= flt_d;
            lock_q  <= lock_d;
            retry_q <= retry_d;
            step_q  <= step_d;
            wdog_q  <= wdog_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
        end
    end

`ifdef QCW_SEQ_BURST_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= 16'd0;
            peak_q <= 8'd0;
        end else begin
            bcnt_q <= bcnt_d;
            peak_q <= peak_d;
        end
    end

    assign burst_cnt  = bcnt_q;
    assign peak_phase = peak_q;
`endif

    assign pll.start       = start_q;
    assign pll.halt        = halt_q;
    assign pll.phase_shift = phase_q;
    assign pll.cycle_limit = 16'(CYCLE_LIMIT);
    assign busy            = busy_q;
    assign fault_latched   = flt_q;
    assign lockout         = lock_q;

endmodule

// File: tb/tb_qcw_burst_sequencer.sv
// Randomized bench for qcw_burst_sequencer with a burst-level model.
// Define QCW_SEQ_BURST_CNT_EN to also check burst_cnt/peak_phase.
module tb_qcw_burst_sequencer;

    localparam int RS   = 16;
    localparam int RE   = 40;
    localparam int STEP = 4;
    localparam int CL   = 2000;
    localparam int COOL = 30;
    localparam int WD   = 64;
    localparam int RL   = 2;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic fire;
    logic busy;
    logic fault_latched;
    logic lockout;
`ifdef QCW_SEQ_BURST_CNT_EN
    logic [15:0] burst_cnt;
    logic [7:0]  peak_phase;
`endif

    qcw_burst_sequencer_if pll ();

    always #5 clk = ~clk;

    qcw_burst_sequencer #(
        .RAMP_START(RS),
        .RAMP_END(RE),
        .RAMP_STEP_CYCLES(STEP),
        .CYCLE_LIMIT(CL),
        .COOLDOWN_CLKS(COOL),
        .WDOG_CLKS(WD),
        .RETRY_LIMIT(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .fire(fire),
        .pll(pll),
        .busy(busy),
        .fault_latched(fault_latched),
        .lockout(lockout)
`ifdef QCW_SEQ_BURST_CNT_EN
        ,
        .burst_cnt(burst_cnt),
        .peak_phase(peak_phase)
`endif
    );

    int checks = 0;
    int failures = 0;

    int exp_retry = 0;
    int exp_fl = 0;
    int exp_lock = 0;
    int exp_bcnt = 0;
    int exp_peak = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_phase(int n);
        int p;
        p = RS + n / STEP;
        return (p > RE) ? RE : p;
    endfunction

    task automatic fire_start(bit stale);
        if (stale) pll.done = 1'b1;
        fire = 1'b1;
        tick();
        check("start_pulse", 32'(pll.start), 1);
        check("busy_start", 32'(busy), 1);
        fire = 1'b0;
        tick();
        check("start_one_clk", 32'(pll.start), 0);
        pll.done = 1'b0;
        tick();
        check("busy_ramp", 32'(busy), 1);
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            pll.cycle_finished = 1'b1;
            tick();
            pll.cycle_finished = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
        end
    endtask

    // Called right after the clock that entered cooldown.
    task automatic wait_cool(string tag);
        int n;
        int starts;
        n = 0;
        starts = 0;
        check({tag, "_cool_halt"}, 32'(pll.halt), 0);
        check({tag, "_cool_phase"}, 32'(pll.phase_shift), RS);
        while (busy && n < COOL + 10) begin
            fire = (n < COOL - 4) && ($urandom_range(0, 2) == 0);
            tick();
            n++;
            if (pll.start) starts++;
        end
        fire = 1'b0;
        check({tag, "_cool_len"}, 32'(n), COOL);
        check({tag, "_cool_nostart"}, 32'(starts), 0);
    endtask

    task automatic lockout_exit();
        int starts;
        starts = 0;
        check("lock_on", 32'(lockout), 1);
        check("lock_busy", 32'(busy), 1);
        fire = 1'b1;
        tick();
        if (pll.start) starts++;
        fire = 1'b0;
        repeat (3) begin
            tick();
            if (pll.start) starts++;
        end
        check("lock_fire_ignored", 32'(starts), 0);
        check("lock_hold", 32'(lockout), 1);
        enable = 1'b0;
        tick();
        check("lock_exit", 32'(lockout), 0);
        check("lock_exit_busy", 32'(busy), 0);
        check("lock_exit_fl", 32'(fault_latched), 32'(exp_fl));
        enable = 1'b1;
        exp_retry = 0;
        exp_lock = 0;
        tick();
    endtask

    task automatic after_fault(string tag);
        exp_retry++;
        exp_fl = 1;
        exp_lock = (exp_retry >= RL) ? 1 : 0;
        check({tag, "_fl"}, 32'(fault_latched), 1);
        tick();
        check({tag, "_lockout"}, 32'(lockout), 32'(exp_lock));
        check({tag, "_busy"}, 32'(busy), 1);
        if (exp_lock != 0) lockout_exit();
        else wait_cool(tag);
    endtask

    task automatic burst_normal(int n, bit stale);
        fire_start(stale);
        pulses(n);
        check("ramp_phase", 32'(pll.phase_shift), 32'(exp_phase(n)));
        check("ramp_busy", 32'(busy), 1);
        pll.done = 1'b1;
        tick();
        pll.done = 1'b0;
        exp_fl = 0;
        exp_bcnt++;
        exp_peak = exp_phase(n);
        check("done_busy", 32'(busy), 1);
        check("done_fl", 32'(fault_latched), 0);
`ifdef QCW_SEQ_BURST_CNT_EN
        check("burst_cnt", 32'(burst_cnt), 32'(exp_bcnt));
        check("peak_phase", 32'(peak_phase), 32'(exp_peak));
`endif
        wait_cool("done");
    endtask

    task automatic burst_abort(int n);
        fire_start(1'b0);
        pulses(n);
        enable = 1'b0;
        tick();
        check("abort_halt", 32'(pll.halt), 1);
        check("abort_phase", 32'(pll.phase_shift), 32'(exp_phase(n)));
        pll.fault = 1'b1;
        tick();
        pll.fault = 1'b0;
        check("abort_fl", 32'(fault_latched), 32'(exp_fl));
        check("abort_lockout", 32'(lockout), 0);
        check("abort_busy", 32'(busy), 1);
        wait_cool("abort");
        enable = 1'b1;
        tick();
    endtask

    task automatic burst_fault(int n, bit with_done);
        fire_start(1'b0);
        pulses(n);
        pll.fault = 1'b1;
        pll.done = with_done;
        tick();
        pll.fault = 1'b0;
        pll.done = 1'b0;
        check("fault_phase_reset", 32'(pll.phase_shift), RS);
        after_fault("fault");
    endtask

    task automatic burst_wdog();
        fire_start(1'b0);
        repeat (WD) tick();
        check("wdog_pending_busy", 32'(busy), 1);
        tick();
        after_fault("wdog");
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        fire = 1'b0;
        pll.cycle_finished = 1'b0;
        pll.done = 1'b0;
        pll.fault = 1'b0;
        repeat (3) tick();
        check("rst_start", 32'(pll.start), 0);
        check("rst_halt", 32'(pll.halt), 0);
        check("rst_phase", 32'(pll.phase_shift), RS);
        check("rst_busy", 32'(busy), 0);
        check("rst_fl", 32'(fault_latched), 0);
        check("rst_lockout", 32'(lockout), 0);
        check("cycle_limit", 32'(pll.cycle_limit), CL);
`ifdef QCW_SEQ_BURST_CNT_EN
        check("rst_burst_cnt", 32'(burst_cnt), 0);
`endif
        rst = 1'b0;
        tick();

        fire = 1'b1;
        tick();
        check("fire_disabled_start", 32'(pll.start), 0);
        check("fire_disabled_busy", 32'(busy), 0);
        fire = 1'b0;
        enable = 1'b1;
        tick();

        burst_normal(20, 1'b0);
        burst_normal(120, 1'b0);
        burst_normal(8, 1'b1);
        burst_abort(6);
        burst_fault(5, 1'b1);
        burst_wdog();

        for (int i = 0; i < 15; i++) begin
            case (i % 5)
                0: burst_normal($urandom_range(0, 130), 1'b0);
                1: burst_normal($urandom_range(0, 40), 1'b1);
                2: burst_abort($urandom_range(0, 40));
                3: burst_fault($urandom_range(0, 40), 1'($urandom_range(0, 1)));
                default: burst_wdog();
            endcase
        end

        fire_start(1'b0);
        pulses(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_retry = 0;
        exp_fl = 0;
        exp_lock = 0;
        exp_bcnt = 0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_phase", 32'(pll.phase_shift), RS);
        check("midrst_halt", 32'(pll.halt), 0);
        check("midrst_fl", 32'(fault_latched), 0);
        check("midrst_lockout", 32'(lockout), 0);
`ifdef QCW_SEQ_BURST_CNT_EN
        check("midrst_burst_cnt", 32'(burst_cnt), 0);
`endif
        tick();
        burst_fault(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
